// File: rtl/ram_stream_reader_pkg.sv
// Shared types and default widths for the RAM burst stream reader.
// Holds the FSM state enum and a small FIFO occupancy helper.
package ram_stream_reader_pkg;

    localparam int RSR_ADDR_W = 4;
    localparam int RSR_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rsr_state_t;

    // Entries already buffered plus the read whose data is still returning.
    function automatic logic [2:0] rsr_occupancy(
        input logic [1:0] count,
        input logic       inflight
    );
        return {1'b0, count} + {2'b00, inflight};
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo2.sv
// rsr_fifo2: two-entry output buffer between RAM read data and the stream.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (head), count.
module rsr_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: reads len words from a sync-read RAM starting at base_addr
// (address wraps) and streams them out over valid/ready with a 2-entry FIFO.
// Ports: clk, rst (sync, active-high), start/base_addr/len request,
// busy/done status, ram_en/ram_we/ram_addr/ram_dout RAM port,
// m_data/m_valid/m_ready stream. Define RSR_LAST_EN to add m_last.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_W = RSR_ADDR_W,
    parameter int DATA_W = RSR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef RSR_LAST_EN
    ,
    output logic              m_last
`endif
);

`ifdef RSR_LAST_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    rsr_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W:0]   len_eff;
    logic              rvalid_q;
    logic              pop;
    logic              can_issue;
    logic [2:0]        occ;
    logic [1:0]        fifo_count;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_head;

    assign len_eff = (len > MAX_LEN) ? MAX_LEN : len;

    assign m_valid = (fifo_count != 2'd0);
    assign pop     = m_valid && m_ready;

    // A read may issue only if its word has a FIFO slot once it returns,
    // counting the beat leaving this cycle.
    assign occ       = rsr_occupancy(fifo_count, rvalid_q);
    assign can_issue = occ < (3'd2 + {2'b00, pop});

    assign ram_en   = (state == RUN) && (rem_q != '0) && can_issue;
    assign ram_we   = 1'b0;
    assign ram_addr = addr_q;

`ifdef RSR_LAST_EN
    logic rlast_q;
    assign fifo_din = {rlast_q, ram_dout};
    assign m_last   = fifo_head[DATA_W] & m_valid;
`else
    assign fifo_din = ram_dout;
`endif
    assign m_data = fifo_head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            rvalid_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rvalid_q <= ram_en;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len_eff == '0) begin
                            done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            addr_q <= base_addr;
                            rem_q  <= len_eff;
                        end
                    end
                end
                RUN: begin
                    if (ram_en) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - ONE;
                        if (rem_q == ONE) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Nothing returning and one word left: this pop ends it.
                    if (pop && (fifo_count == 2'd1) && !rvalid_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RSR_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rlast_q <= 1'b0;
        end else begin
            rlast_q <= ram_en && (rem_q == ONE);
        end
    end
`endif

    // Reset clears rvalid_q, so data returning right after reset is dropped.
    rsr_fifo2 #(
        .W(FW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rvalid_q),
        .din  (fifo_din),
        .pop  (pop),
        .dout (fifo_head),
        .count(fifo_count)
    );

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (16 locations).
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr  input  ADDR_W  first RAM address of the burst, sampled with start.
REQ-007 SHALL have port len  input  ADDR_W+1  beat count 0..16, sampled with start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have ports ram_en, ram_we (output, 1) and ram_addr (output, ADDR_W) driving a synchronous-read RAM port.
REQ-011 SHALL have port ram_dout  input  DATA_W  RAM read data, valid the cycle after ram_en.
REQ-012 SHALL have ports m_data (output, DATA_W), m_valid (output, 1), m_ready (input, 1): valid/ready stream out.

Function
REQ-013 SHALL drive ram_we constantly 0; this block only reads.
REQ-014 SHALL implement FSM IDLE -> RUN on start with len!=0; RUN -> DRAIN after the last read issues; DRAIN -> IDLE when the last beat handshakes.
REQ-015 SHALL clamp len values above 16 to 16.
REQ-016 SHALL, on start with len==0, skip all reads, keep busy low and pulse done in the next cycle.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL issue reads at base_addr, base_addr+1, ..., with ram_addr wrapping modulo 2**ADDR_W (e.g. base 14, len 4 -> 14,15,0,1).
REQ-019 SHALL push ram_dout into a 2-entry output FIFO in the cycle after each ram_en.
REQ-020 SHALL assert ram_en only when fifo_count + inflight - (m_valid & m_ready) < 2, so the FIFO never overflows.
REQ-021 SHALL achieve one beat per cycle while m_ready stays high; first m_valid SHALL appear 3 cycles after start is sampled.
REQ-022 SHALL present m_data from the FIFO head and hold m_valid/m_data stable until m_ready.
REQ-023 SHALL pulse done in the cycle after the final beat handshakes, with busy dropping in the same cycle.

Reset
REQ-024 SHALL, on rst, return the FSM to IDLE, flush the FIFO and clear inflight in the same edge, including mid-burst.
REQ-025 SHALL reset outputs to: busy=0, done=0, ram_en=0, ram_we=0, ram_addr=0, m_valid=0, m_data=0.
REQ-026 SHALL discard RAM data returning in the cycle after reset and SHALL NOT push it.

Configuration
REQ-027 SHALL, with RSR_LAST_EN defined, add output m_last (1 bit) asserted with the final beat of each burst, reset value 0.
REQ-028 SHALL, without RSR_LAST_EN, omit m_last; all other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, RUN, DRAIN) and the default widths in package ram_stream_reader_pkg.
REQ-030 SHALL implement the 2-entry output buffer as sub-module rsr_fifo2 (push, pop, count, data).

Verification
REQ-031 SHALL cover: RAM preloaded mem[i]=8'hA0+i, base 0, len 4, m_ready=1 -> beats A0,A1,A2,A3 on consecutive cycles, first m_valid 3 cycles after start, done 1 cycle after the last beat.
REQ-032 SHALL cover: base 14, len 4 -> ram_addr 14,15,0,1 and beats AE,AF,A0,A1.
REQ-033 SHALL cover: len 16, m_ready toggling 1-0-1-0 -> all 16 beats in order, none lost or duplicated, ram_en never active while FIFO plus inflight is full.
REQ-034 SHALL cover: len 0 -> no ram_en, busy stays 0, done pulses 1 cycle after start.
REQ-035 SHALL cover: rst asserted after 2 of 8 beats -> next cycle m_valid=0, busy=0, and a new start with base 3, len 2 yields A3,A4.
REQ-036 SHALL cover, with RSR_LAST_EN: len 3 -> m_last high only on the third beat.
